// File: rtl/puf_ro_key_sequencer_if.sv
// rtl/puf_ro_key_sequencer_if.sv - request/key handshake bundle between host and RO PUF key sequencer
interface puf_ro_key_sequencer_if #(
  parameter int SIZE      = 8,
  parameter int RESP_BITS = 16
);
  logic                 start;
  logic [SIZE-1:0]      seed;
  logic                 busy;
  logic [RESP_BITS-1:0] key;
  logic                 key_valid;
  logic                 key_ready;

  // master is the host requesting keys; slave is the sequencer
  modport master (output start, seed, key_ready, input busy, key, key_valid);
  modport slave  (input start, seed, key_ready, output busy, key, key_valid);
endinterface

// File: rtl/puf_ro_key_sequencer.sv
// rtl/puf_ro_key_sequencer.sv - RO PUF challenge/enable sequencer assembling a RESP_BITS key
// Optional PUF_MAJORITY_EN: each key bit is the 2-of-3 vote of three evaluations of one challenge.
module puf_ro_key_sequencer #(
  parameter int SIZE          = 8,
  parameter int RESP_BITS     = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int MEAS_CYCLES   = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  puf_ro_key_sequencer_if.slave ctl_if,
  output logic                  puf_enable_o,
  output logic [SIZE-1:0]       puf_challenge_o,
  input  logic                  puf_response_i
);

  localparam int HALF    = SIZE / 2;
  localparam int CNT_MAX = (MEAS_CYCLES > SETTLE_CYCLES) ? MEAS_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] MEAS_LAST   = CW'(MEAS_CYCLES - 1);
  localparam logic [CW-1:0] SYNC_LAST   = CW'(1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEASURE, S_SYNC, S_CAPTURE, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [SIZE-1:0]      chal_q, chal_d;
  logic [RESP_BITS-1:0] key_q, key_d;
  logic                 sync1_q, sync2_q;
  logic                 last_eval;
  logic                 key_bit;

  // A challenge with equal halves compares an RO to itself; all-ones needs two steps (wraps to 0).
  function automatic logic [SIZE-1:0] fixup(input logic [SIZE-1:0] c);
    logic [SIZE-1:0] c1;
    logic [SIZE-1:0] c2;
    c1 = c + SIZE'(1);
    c2 = c + SIZE'(2);
    if (c[HALF-1:0] != c[SIZE-1:HALF])
      return c;
    else if (c1[HALF-1:0] != c1[SIZE-1:HALF])
      return c1;
    else
      return c2;
  endfunction

`ifdef PUF_MAJORITY_EN
  logic [1:0] eval_q, eval_d;
  logic [1:0] votes_q, votes_d;

  assign last_eval = (eval_q == 2'd2);
  assign key_bit   = votes_q[1] | (votes_q[0] & sync2_q);
`else
  assign last_eval = 1'b1;
  assign key_bit   = sync2_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      chal_q  <= '0;
      key_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
`ifdef PUF_MAJORITY_EN
      eval_q  <= '0;
      votes_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      chal_q  <= chal_d;
      key_q   <= key_d;
      sync1_q <= puf_response_i;
      sync2_q <= sync1_q;
`ifdef PUF_MAJORITY_EN
      eval_q  <= eval_d;
      votes_q <= votes_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (ctl_if.start) state_d = S_SETTLE;
      S_SETTLE:  if (cnt_q == SETTLE_LAST) state_d = S_MEASURE;
      S_MEASURE: if (cnt_q == MEAS_LAST) state_d = S_SYNC;
      S_SYNC:    if (cnt_q == SYNC_LAST) state_d = S_CAPTURE;
      S_CAPTURE: state_d = (last_eval && idx_q == IDX_LAST) ? S_DONE : S_SETTLE;
      S_DONE:    if (ctl_if.key_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = '0;
    idx_d  = idx_q;
    chal_d = chal_q;
    key_d  = key_q;
`ifdef PUF_MAJORITY_EN
    eval_d  = eval_q;
    votes_d = votes_q;
`endif
    if (state_d == state_q &&
        (state_q == S_SETTLE || state_q == S_MEASURE || state_q == S_SYNC))
      cnt_d = cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (ctl_if.start) begin
          chal_d = fixup(ctl_if.seed);
          key_d  = '0;
          idx_d  = '0;
`ifdef PUF_MAJORITY_EN
          eval_d  = '0;
          votes_d = '0;
`endif
        end
      end
      S_CAPTURE: begin
`ifdef PUF_MAJORITY_EN
        if (last_eval) begin
          eval_d  = '0;
          votes_d = '0;
        end else begin
          eval_d  = eval_q + 2'd1;
          votes_d = votes_q + {1'b0, sync2_q};
        end
`endif
        if (last_eval) begin
          key_d[idx_q] = key_bit;
          if (idx_q != IDX_LAST) begin
            idx_d  = idx_q + IW'(1);
            chal_d = fixup(chal_q + SIZE'(1));
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ctl_if.busy      = (state_q != S_IDLE);
    ctl_if.key_valid = (state_q == S_DONE);
    ctl_if.key       = key_q;
    puf_enable_o     = (state_q == S_MEASURE) || (state_q == S_SYNC) || (state_q == S_CAPTURE);
    puf_challenge_o  = chal_q;
  end

endmodule

// File: tb/tb_puf_ro_key_sequencer.sv
// tb/tb_puf_ro_key_sequencer.sv - bench for puf_ro_key_sequencer (default and small-parameter instances)
module tb_puf_ro_key_sequencer;

`ifdef PUF_MAJORITY_EN
  localparam int EVALS = 3;
`else
  localparam int EVALS = 1;
`endif
  localparam int LAT0 = 16 * (4 + 1024 + 3) * EVALS;
  localparam int RB1  = 4;
  localparam int ST1  = 2;
  localparam int MS1  = 8;
  localparam int LAT1 = RB1 * (ST1 + MS1 + 3) * EVALS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, rst1_n;
  logic       en0, en1;
  logic [7:0] chal0, chal1;
  logic       resp0;
  logic       resp1 = 1'b0;

  puf_ro_key_sequencer_if #(.SIZE(8), .RESP_BITS(16)) if0 ();
  puf_ro_key_sequencer_if #(.SIZE(8), .RESP_BITS(RB1)) if1 ();

  puf_ro_key_sequencer dut0 (
    .clk_i(clk), .rst_ni(rst0_n), .ctl_if(if0),
    .puf_enable_o(en0), .puf_challenge_o(chal0), .puf_response_i(resp0)
  );

  puf_ro_key_sequencer #(.SIZE(8), .RESP_BITS(RB1), .SETTLE_CYCLES(ST1), .MEAS_CYCLES(MS1)) dut1 (
    .clk_i(clk), .rst_ni(rst1_n), .ctl_if(if1),
    .puf_enable_o(en1), .puf_challenge_o(chal1), .puf_response_i(resp1)
  );

  // PUF model for the default instance: RO A (low nibble) faster than RO B
  assign resp0 = (chal0[3:0] > chal0[7:4]);

  int          tests = 0;
  int          fails = 0;
  int          viol0 = 0;
  int          viol1 = 0;
  logic [7:0]  log0[$];
  logic [7:0]  log1[$];
  bit          rlog1[$];
  bit          use_pat1 = 1'b0;
  logic [11:0] pat1 = '0;
  int          eidx1 = 0;
  logic        en0_p = 1'b0, en1_p = 1'b0;
  logic [7:0]  c0_p = '0, c1_p = '0;

  typedef struct {
    logic [7:0]  seed;
    logic [11:0] pat;
    logic [31:0] chals;
    logic [3:0]  key1;
    logic [3:0]  key3;
  } vec_t;
  vec_t vt[4];

  initial forever begin
    @(posedge en0);
    log0.push_back(chal0);
  end

  initial forever begin
    @(posedge en1);
    log1.push_back(chal1);
    if (use_pat1 && eidx1 < 12) resp1 = pat1[eidx1];
    else resp1 = 1'($urandom_range(0, 1));
    rlog1.push_back(resp1);
    eidx1++;
  end

  initial forever begin
    @(negedge clk);
    if (en0 && en0_p && chal0 !== c0_p) viol0++;
    if (en1 && en1_p && chal1 !== c1_p) viol1++;
    en0_p = en0; c0_p = chal0;
    en1_p = en1; c1_p = chal1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fix(input logic [7:0] c);
    logic [7:0] x;
    x = c;
    while (x[3:0] == x[7:4]) x = x + 8'd1;
    return x;
  endfunction

  function automatic logic [7:0] model_chal(input logic [7:0] seed, input int n);
    logic [7:0] x;
    x = fix(seed);
    for (int k = 0; k < n; k++) x = fix(x + 8'd1);
    return x;
  endfunction

  task automatic run1(input string name, input logic [7:0] seed, input bit use_pat,
                      input logic [11:0] pat, input bit has_tbl,
                      input logic [31:0] tbl_chals, input logic [3:0] tbl_key);
    int         cyc;
    int         ones;
    logic [3:0] mkey;
    log1.delete(); rlog1.delete();
    eidx1 = 0; use_pat1 = use_pat; pat1 = pat; viol1 = 0;
    @(negedge clk);
    if1.start = 1'b1; if1.seed = seed;
    @(negedge clk);
    if1.start = 1'b0; if1.seed = 8'($urandom);
    chk({name, " busy"}, 32'(if1.busy), 1);
    cyc = 0;
    while (!if1.key_valid && cyc < LAT1 + 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " latency"}, cyc, LAT1);
    chk({name, " evals"}, log1.size(), RB1 * EVALS);
    for (int i = 0; i < RB1 * EVALS && i < log1.size(); i++)
      chk({name, " chal"}, 32'(log1[i]), 32'(model_chal(seed, i / EVALS)));
    mkey = '0;
    for (int b = 0; b < RB1; b++) begin
      ones = 0;
      for (int e = 0; e < EVALS; e++)
        if (b * EVALS + e < rlog1.size()) ones += int'(rlog1[b * EVALS + e]);
      mkey[b] = (2 * ones > EVALS);
    end
    chk({name, " key model"}, 32'(if1.key), 32'(mkey));
    if (has_tbl) begin
      chk({name, " key table"}, 32'(if1.key), 32'((EVALS == 3) ? tbl_key : pat[3:0]));
      for (int i = 0; i < RB1; i++)
        if (i * EVALS < log1.size())
          chk({name, " chal table"}, 32'(log1[i * EVALS]), 32'(8'(tbl_chals >> (24 - 8 * i))));
    end
    chk({name, " chal stable"}, viol1, 0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    chk({name, " valid held"}, 32'(if1.key_valid), 1);
    if1.key_ready = 1'b1;
    @(negedge clk);
    if1.key_ready = 1'b0;
    chk({name, " valid drop"}, 32'(if1.key_valid), 0);
    chk({name, " busy drop"}, 32'(if1.busy), 0);
  endtask

  initial begin
    int         cyc;
    bit         stable;
    int         nlog;
    logic [15:0] kept;
    logic [15:0] ekey;
    logic [7:0]  mc;

    vt[0] = '{8'hFE, 12'h0E5, 32'hFE010203, 4'h5, 4'h5};
    vt[1] = '{8'hFF, 12'h5CE, 32'h01020304, 4'hE, 4'h5};
    vt[2] = '{8'h33, 12'hFFF, 32'h34353637, 4'hF, 4'hF};
    vt[3] = '{8'h42, 12'h0F0, 32'h42434546, 4'h0, 4'h6};

    rst0_n = 1'b0; rst1_n = 1'b0;
    if0.start = 1'b0; if0.seed = '0; if0.key_ready = 1'b0;
    if1.start = 1'b0; if1.seed = '0; if1.key_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(if0.busy), 0);
    chk("rst enable", 32'(en0), 0);
    chk("rst challenge", 32'(chal0), 0);
    chk("rst key", 32'(if0.key), 0);
    chk("rst key_valid", 32'(if0.key_valid), 0);
    chk("rst small busy", 32'(if1.busy), 0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run1($sformatf("vec%0d", i), vt[i].seed, 1'b1, vt[i].pat, 1'b1, vt[i].chals,
           (EVALS == 3) ? vt[i].key3 : vt[i].key1);
    for (int r = 0; r < 6; r++)
      run1($sformatf("rand%0d", r), 8'($urandom), 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);

    @(negedge clk);
    if1.start = 1'b1; if1.seed = 8'h77;
    @(negedge clk);
    if1.start = 1'b0;
    repeat ($urandom_range(5, LAT1 - 5)) @(negedge clk);
    rst1_n = 1'b0;
    @(negedge clk);
    rst1_n = 1'b1;
    chk("small midrst busy", 32'(if1.busy), 0);
    chk("small midrst enable", 32'(en1), 0);
    chk("small midrst challenge", 32'(chal1), 0);
    chk("small midrst key", 32'(if1.key), 0);
    chk("small midrst valid", 32'(if1.key_valid), 0);
    run1("after_rst", 8'($urandom), 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);

    log0.delete(); viol0 = 0;
    @(negedge clk);
    if0.start = 1'b1; if0.seed = 8'h21;
    @(negedge clk);
    if0.start = 1'b0;
    chk("main busy", 32'(if0.busy), 1);
    cyc = 0;
    while (!if0.key_valid && cyc < LAT0 + 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 100) begin
        if0.start = 1'b1; if0.seed = 8'h55;
      end else begin
        if0.start = 1'b0;
      end
    end
    if0.start = 1'b0;
    chk("main latency", cyc, LAT0);
    chk("main evals", log0.size(), 16 * EVALS);
    ekey = '0;
    for (int b = 0; b < 16; b++) begin
      mc = model_chal(8'h21, b);
      ekey[b] = (mc[3:0] > mc[7:4]);
      for (int e = 0; e < EVALS; e++)
        if (b * EVALS + e < log0.size())
          chk("main chal", 32'(log0[b * EVALS + e]), 32'(mc));
    end
    chk("main key", 32'(if0.key), 32'(ekey));
    chk("main chal stable", viol0, 0);

    kept = if0.key; stable = 1'b1; nlog = log0.size();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 10) begin
        if0.start = 1'b1; if0.seed = 8'h55;
      end else begin
        if0.start = 1'b0;
      end
      if (!(if0.key_valid === 1'b1 && if0.key === kept && if0.busy === 1'b1 && en0 === 1'b0))
        stable = 1'b0;
    end
    if0.start = 1'b0;
    chk("done hold stable", 32'(stable), 1);
    chk("done no new eval", log0.size(), nlog);
    if0.key_ready = 1'b1;
    @(negedge clk);
    if0.key_ready = 1'b0;
    chk("done valid drop", 32'(if0.key_valid), 0);
    chk("done busy drop", 32'(if0.busy), 0);
    @(negedge clk);
    chk("done no queued start", 32'(if0.busy), 0);

    if0.start = 1'b1; if0.seed = 8'h10;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (1999) @(negedge clk);
    rst0_n = 1'b0;
    @(negedge clk);
    rst0_n = 1'b1;
    chk("midrst busy", 32'(if0.busy), 0);
    chk("midrst enable", 32'(en0), 0);
    chk("midrst challenge", 32'(chal0), 0);
    chk("midrst key", 32'(if0.key), 0);
    chk("midrst valid", 32'(if0.key_valid), 0);
    @(negedge clk);
    chk("midrst stays idle", 32'(if0.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
